// File: rtl/sysid_pkg.sv
// sysid_pkg: register map, CAPS/CTRL bit positions and byte-merge helper for sysid_regbank.
package sysid_pkg;
    typedef enum logic [2:0] {
        REG_SYSTEM_ID,
        REG_BUILD_TS,
        REG_CAPS,
        REG_SCRATCH,
        REG_UPTIME_LO,
        REG_UPTIME_HI,
        REG_CTRL,
        REG_RSVD
    } reg_addr_e;

    localparam int CAPS_UPTIME_BIT = 0;
    localparam int CAPS_VERSION_LSB = 8;
    localparam int CTRL_CLEAR_BIT = 0;
    localparam int CTRL_FREEZE_BIT = 1;

    function automatic logic [31:0] byte_merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i+:8] = wd[8*i+:8];
        return r;
    endfunction
endpackage

// File: rtl/sysid_regbank_if.sv
// sysid_regbank_if: Avalon-MM slave bus (no waitrequest, fixed 1-cycle read latency).
interface sysid_regbank_if;
    logic [2:0] address;
    logic read;
    logic write;
    logic [31:0] writedata;
    logic [3:0] byteenable;
    logic [31:0] readdata;
    logic readdatavalid;
    modport master(output address, read, write, writedata, byteenable, input readdata, readdatavalid);
    modport slave(input address, read, write, writedata, byteenable, output readdata, readdatavalid);
endinterface

// File: rtl/sysid_uptime_ctr.sv
// sysid_uptime_ctr: 64-bit free-running uptime counter; clear wins over increment, freeze holds.
module sysid_uptime_ctr (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic freeze,
    output logic [63:0] count
);
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) count <= '0;
        else if (clear) count <= '0;
        else if (!freeze) count <= count + 64'd1;
endmodule

// File: rtl/sysid_regbank.sv
// sysid_regbank: system ID / build info / scratch register bank on Avalon-MM.
// Optional uptime counter, shadow and CTRL are built only with SYSID_UPTIME_EN defined.
module sysid_regbank
    import sysid_pkg::*;
#(
    parameter logic [31:0] SYSTEM_ID = 32'h0000_0000,
    parameter logic [31:0] BUILD_TIMESTAMP = 32'h0000_0000,
    parameter logic [7:0]  VERSION = 8'h01,
    parameter logic [31:0] SCRATCH_RST = 32'h0000_0000
) (
    input logic clock,
    input logic reset_n,
    sysid_regbank_if.slave bus
);
    logic [31:0] scratch;
    logic [31:0] caps;
    logic [31:0] rd_mux;
    logic [31:0] up_lo;
    logic [31:0] up_hi;
    logic [31:0] ctrl_rd;
    logic cap_up;

`ifdef SYSID_UPTIME_EN
    logic [63:0] count;
    logic [31:0] shadow;
    logic freeze;
    logic ctrl_wr;
    logic clear;
    assign ctrl_wr = bus.write && bus.address == REG_CTRL;
    assign clear = ctrl_wr && bus.writedata[CTRL_CLEAR_BIT];
    sysid_uptime_ctr u_ctr (
        .clock(clock),
        .reset_n(reset_n),
        .clear(clear),
        .freeze(freeze),
        .count(count)
    );
    // Latching the high word on a low-word read gives software a tear-free 64-bit snapshot.
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            shadow <= '0;
            freeze <= 1'b0;
        end else begin
            if (bus.read && bus.address == REG_UPTIME_LO) shadow <= count[63:32];
            if (ctrl_wr) freeze <= bus.writedata[CTRL_FREEZE_BIT];
        end
    assign up_lo = count[31:0];
    assign up_hi = shadow;
    assign ctrl_rd = 32'(freeze) << CTRL_FREEZE_BIT;
    assign cap_up = 1'b1;
`else
    assign up_lo = '0;
    assign up_hi = '0;
    assign ctrl_rd = '0;
    assign cap_up = 1'b0;
`endif

    always_comb begin
        caps = '0;
        caps[CAPS_VERSION_LSB+:8] = VERSION;
        caps[CAPS_UPTIME_BIT] = cap_up;
        rd_mux = '0;
        case (bus.address)
            REG_SYSTEM_ID: rd_mux = SYSTEM_ID;
            REG_BUILD_TS:  rd_mux = BUILD_TIMESTAMP;
            REG_CAPS:      rd_mux = caps;
            REG_SCRATCH:   rd_mux = scratch;
            REG_UPTIME_LO: rd_mux = up_lo;
            REG_UPTIME_HI: rd_mux = up_hi;
            REG_CTRL:      rd_mux = ctrl_rd;
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) scratch <= SCRATCH_RST;
        else if (bus.write && bus.address == REG_SCRATCH)
            scratch <= byte_merge(scratch, bus.writedata, bus.byteenable);

    // Read data is captured from pre-edge state, so a same-cycle write is not visible yet.
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            bus.readdata <= '0;
            bus.readdatavalid <= 1'b0;
        end else begin
            bus.readdata <= bus.read ? rd_mux : '0;
            bus.readdatavalid <= bus.read;
        end
endmodule

// File: tb/tb_sysid_regbank.sv
// tb_sysid_regbank: table vectors, corner sequences and random traffic against a behavioural model.
// Covers both builds; the uptime sequences run only with SYSID_UPTIME_EN defined.
module tb_sysid_regbank;
    localparam logic [31:0] SID = 32'hC0DE_1234;
    localparam logic [31:0] BTS = 32'h6512_3456;
    localparam logic [7:0]  VER = 8'h01;
`ifdef SYSID_UPTIME_EN
    localparam bit UP = 1'b1;
`else
    localparam bit UP = 1'b0;
`endif
    localparam logic [31:0] CAPS = {16'h0, VER, 7'h0, UP};

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    sysid_regbank_if bus();
    sysid_regbank #(
        .SYSTEM_ID(SID),
        .BUILD_TIMESTAMP(BTS),
        .VERSION(VER),
        .SCRATCH_RST(32'h0)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    logic [31:0] m_scratch;
    logic [31:0] m_shadow;
    logic [63:0] m_count;
    logic m_freeze;

    typedef struct {
        logic rd;
        logic wr;
        logic [2:0] a;
        logic [31:0] wd;
        logic [3:0] be;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[16];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", n, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0: return SID;
            3'd1: return BTS;
            3'd2: return CAPS;
            3'd3: return m_scratch;
            3'd4: return UP ? m_count[31:0] : 32'h0;
            3'd5: return UP ? m_shadow : 32'h0;
            3'd6: return UP ? {30'h0, m_freeze, 1'b0} : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        bus.read = 1'b0;
        bus.write = 1'b0;
        bus.address = '0;
        bus.writedata = '0;
        bus.byteenable = '0;
        m_scratch = '0;
        m_shadow = '0;
        m_count = '0;
        m_freeze = 1'b0;
        #1;
        chk("reset rdv", 32'(bus.readdatavalid), 32'h0);
        chk("reset data", bus.readdata, 32'h0);
        @(posedge clock);
        @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    // One bus cycle: drive, clock, then sample the response to this cycle's read.
    task automatic bus_cycle(input logic rd, input logic wr, input logic [2:0] a, input logic [31:0] wd,
                             input logic [3:0] be, output logic [31:0] rdata, output logic rdv,
                             output logic [31:0] exp);
        exp = rd ? m_read(a) : 32'h0;
        bus.read = rd;
        bus.write = wr;
        bus.address = a;
        bus.writedata = wd;
        bus.byteenable = be;
        @(posedge clock);
        #1;
        rdata = bus.readdata;
        rdv = bus.readdatavalid;
        bus.read = 1'b0;
        bus.write = 1'b0;
        if (UP && rd && a == 3'd4) m_shadow = m_count[63:32];
        if (wr && a == 3'd3)
            for (int i = 0; i < 4; i++)
                if (be[i]) m_scratch[8*i+:8] = wd[8*i+:8];
        if (UP) begin
            if (wr && a == 3'd6 && wd[0]) m_count = '0;
            else if (!m_freeze) m_count = m_count + 64'd1;
            if (wr && a == 3'd6) m_freeze = wd[1];
        end
    endtask

    task automatic xfer(input string n, input logic rd, input logic wr, input logic [2:0] a,
                        input logic [31:0] wd, input logic [3:0] be, output logic [31:0] rdata);
        logic rdv;
        logic [31:0] exp;
        bus_cycle(rd, wr, a, wd, be, rdata, rdv, exp);
        chk({n, " rdv"}, 32'(rdv), 32'(rd));
        chk({n, " data"}, rdata, exp);
    endtask

    initial begin
        logic [31:0] rdata;
        logic [31:0] exp;
        logic rdv;
        tbl[0]  = '{1, 0, 3'd0, 32'h0, 4'h0, SID};
        tbl[1]  = '{1, 0, 3'd1, 32'h0, 4'h0, BTS};
        tbl[2]  = '{1, 0, 3'd2, 32'h0, 4'h0, CAPS};
        tbl[3]  = '{1, 0, 3'd3, 32'h0, 4'h0, 32'h0};
        tbl[4]  = '{0, 1, 3'd3, 32'hDEAD_BEEF, 4'b0101, 32'h0};
        tbl[5]  = '{1, 0, 3'd3, 32'h0, 4'h0, 32'h00AD_00EF};
        tbl[6]  = '{0, 1, 3'd3, 32'h0, 4'hF, 32'h0};
        tbl[7]  = '{1, 1, 3'd3, 32'h1234_5678, 4'hF, 32'h0};
        tbl[8]  = '{1, 0, 3'd3, 32'h0, 4'h0, 32'h1234_5678};
        tbl[9]  = '{0, 1, 3'd0, 32'hFFFF_FFFF, 4'hF, 32'h0};
        tbl[10] = '{1, 0, 3'd0, 32'h0, 4'h0, SID};
        tbl[11] = '{0, 1, 3'd7, 32'hFFFF_FFFF, 4'hF, 32'h0};
        tbl[12] = '{1, 0, 3'd7, 32'h0, 4'h0, 32'h0};
        tbl[13] = '{0, 1, 3'd2, 32'hFFFF_FFFF, 4'hF, 32'h0};
        tbl[14] = '{1, 0, 3'd2, 32'h0, 4'h0, CAPS};
        tbl[15] = '{0, 0, 3'd0, 32'h0, 4'h0, 32'h0};

        do_reset();
        for (int i = 0; i < 16; i++) begin
            bus_cycle(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].be, rdata, rdv, exp);
            chk($sformatf("vec%0d rdv", i), 32'(rdv), 32'(tbl[i].rd));
            chk($sformatf("vec%0d data", i), rdata, tbl[i].exp);
        end

        for (int a = 4; a < 7; a++) begin
            xfer($sformatf("opt rd%0d", a), 1, 0, 3'(a), 32'h0, 4'h0, rdata);
            if (!UP) chk($sformatf("opt zero%0d", a), rdata, 32'h0);
        end
        xfer("opt wr5", 0, 1, 3'd5, 32'hFFFF_FFFF, 4'hF, rdata);
        xfer("opt rd5b", 1, 0, 3'd5, 32'h0, 4'h0, rdata);

`ifdef SYSID_UPTIME_EN
        xfer("frz wr", 0, 1, 3'd6, 32'h2, 4'hF, rdata);
        xfer("frz lo1", 1, 0, 3'd4, 32'h0, 4'h0, rdata);
        repeat (4) xfer("frz idle", 0, 0, 3'd0, 32'h0, 4'h0, rdata);
        xfer("frz lo2", 1, 0, 3'd4, 32'h0, 4'h0, rdata);
        xfer("frz ctrl", 1, 0, 3'd6, 32'h0, 4'h0, rdata);
        chk("frz ctrl val", rdata, 32'h2);
        xfer("clr wr", 0, 1, 3'd6, 32'h1, 4'hF, rdata);
        xfer("clr lo", 1, 0, 3'd4, 32'h0, 4'h0, rdata);
        chk("clr small", 32'(rdata < 32'd4), 32'h1);
        xfer("f2 wr", 0, 1, 3'd6, 32'h2, 4'hF, rdata);
        force dut.u_ctr.count = 64'h0000_0000_FFFF_FFFF;
        #1 release dut.u_ctr.count;
        m_count = 64'h0000_0000_FFFF_FFFF;
        xfer("unfrz", 0, 1, 3'd6, 32'h0, 4'hF, rdata);
        xfer("tear lo", 1, 0, 3'd4, 32'h0, 4'h0, rdata);
        chk("tear lo val", rdata, 32'hFFFF_FFFF);
        xfer("tear hi", 1, 0, 3'd5, 32'h0, 4'h0, rdata);
        chk("tear hi val", rdata, 32'h0);
        xfer("tear lo2", 1, 0, 3'd4, 32'h0, 4'h0, rdata);
        xfer("tear hi2", 1, 0, 3'd5, 32'h0, 4'h0, rdata);
        chk("tear hi2 val", rdata, 32'h1);
        xfer("clr+rd", 1, 1, 3'd6, 32'h1, 4'hF, rdata);
        xfer("post clr lo", 1, 0, 3'd4, 32'h0, 4'h0, rdata);
        chk("post clr val", rdata, 32'h0);
`endif

        bus_cycle(1, 0, 3'd1, 32'h0, 4'h0, rdata, rdv, exp);
        chk("async pre rdv", 32'(rdv), 32'h1);
        do_reset();
        repeat (2) xfer("async post", 0, 0, 3'd0, 32'h0, 4'h0, rdata);

        bus.read = 1'b1;
        bus.address = 3'd0;
        @(negedge clock);
        do_reset();
        repeat (3) xfer("inflight", 0, 0, 3'd0, 32'h0, 4'h0, rdata);
        xfer("rst scratch", 1, 0, 3'd3, 32'h0, 4'h0, rdata);
        chk("rst scratch val", rdata, 32'h0);

        for (int i = 0; i < 400; i++)
            xfer("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 $urandom, 4'($urandom_range(0, 15)), rdata);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sysid_regbank.md
SYSID_REGBANK -- requirements
Module: sysid_regbank

Interface
REQ-001 SYSTEM_ID, 32'h0000_0000, value returned at register 0.
REQ-002 BUILD_TIMESTAMP, 32'h0000_0000, build time in Unix seconds, returned at register 1.
REQ-003 VERSION, 8'h01, block revision, reported in CAPS[15:8].
REQ-004 SCRATCH_RST, 32'h0000_0000, reset value of SCRATCH.
REQ-005 clock  input  1  single clock; all state updates on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 address  input  3  Avalon-MM word address.
REQ-008 read  input  1  read strobe.
REQ-009 write  input  1  write strobe.
REQ-010 writedata  input  32  write data.
REQ-011 byteenable  input  4  per-byte write enable.
REQ-012 readdata  output  32  read data; valid only while readdatavalid is high.
REQ-013 readdatavalid  output  1  one-cycle pulse, one per accepted read.

Function
REQ-014 Shall have no waitrequest: every read and write is accepted in the cycle it is presented.
REQ-015 Read latency shall be exactly 1 cycle: a read at cycle N gives readdatavalid=1 and readdata at N+1.
REQ-016 readdata shall be 0 in any cycle where readdatavalid is 0.
REQ-017 Register map:
- 0 SYSTEM_ID (RO)
- 1 BUILD_TIMESTAMP (RO)
- 2 CAPS (RO): bit0 = uptime present, [15:8] = VERSION, all other bits 0
- 3 SCRATCH (RW)
- 4 UPTIME_LO (RO)
- 5 UPTIME_HI (RO, shadow)
- 6 CTRL: bit0 CLEAR is write-1 and self-clearing; bit1 FREEZE is RW
- 7 reserved: reads 0
REQ-018 SCRATCH writes shall update only the bytes whose byteenable bit is set.
REQ-019 Writes to RO or reserved addresses shall be ignored.
REQ-020 The uptime counter shall be 64 bits, increment by 1 every cycle while FREEZE=0, and wrap from all-ones to 0.
REQ-021 A read of UPTIME_LO shall:
- return counter[31:0] as sampled in the read cycle;
- in that same cycle, load counter[63:32] into the UPTIME_HI shadow.
REQ-022 A read of UPTIME_HI shall return the shadow value and shall not alter the shadow.
REQ-023 Writing CTRL with bit0=1 shall zero the counter on the next edge; this clear takes precedence over the increment.
REQ-024 If a read and a write occur in the same cycle, the read shall return the pre-write value.
REQ-025 If a read and write both occur in one cycle, the write shall still take effect.
REQ-026 A read of UPTIME_LO in the same cycle as a CLEAR write shall return the pre-clear count.
REQ-027 A CTRL read shall return bit0=0 and the current FREEZE value in bit1.

Reset
REQ-028 On reset_n=0, the following shall be forced asynchronously:
- readdatavalid=0, readdata=0
- counter=0, UPTIME_HI shadow=0
- FREEZE=0
- SCRATCH=SCRATCH_RST
REQ-029 A read in flight when reset is asserted shall be discarded: no readdatavalid pulse after reset is released.
REQ-030 After reset_n deasserts, the counter shall begin counting on the first rising edge of clock.

Configuration
REQ-031 With SYSID_UPTIME_EN defined, the uptime counter, the shadow and CTRL shall be implemented, and CAPS[0]=1.
REQ-032 Without SYSID_UPTIME_EN:
- the counter, shadow and CTRL shall not be synthesised;
- addresses 4-6 shall read 0 and ignore writes;
- CAPS[0]=0.

Structure
REQ-033 A shared package sysid_pkg shall hold:
- the register address constants;
- the CAPS bit positions;
- the CTRL bit positions.
REQ-034 The 64-bit counter with CLEAR and FREEZE shall be a sub-module named sysid_uptime_ctr, instantiated only under SYSID_UPTIME_EN.

Verification
REQ-035 Reset, then read addresses 0 to 2 -> SYSTEM_ID, then BUILD_TIMESTAMP, then CAPS={16'h0,VERSION,7'h0,1'b1}, each with readdatavalid exactly 1 cycle after its read.
REQ-036 Write SCRATCH=32'hDEAD_BEEF with byteenable=4'b0101 from 0, then read -> 32'h00AD_00EF.
REQ-037 Write and read SCRATCH in the same cycle with new value 32'h1234_5678 (old value 0) -> that read returns 0; the next read returns 32'h1234_5678.
REQ-038 Force the counter to 64'h0000_0000_FFFF_FFFF, read UPTIME_LO then UPTIME_HI -> 32'hFFFF_FFFF then 32'h0000_0000, with no tearing.
REQ-039 Write CTRL=2'b10 (FREEZE=1), read UPTIME_LO twice 5 cycles apart -> equal values; write CTRL=1 -> next UPTIME_LO read is under 4.
REQ-040 Assert reset_n low in the cycle after a read -> no readdatavalid pulse and readdata=0; with SYSID_UPTIME_EN undefined, address 4 reads 0 and CAPS[0]=0.
